// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, then releases the CPU.
// Optional trailing-checksum verification is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    input  logic [31:0]       cpu_imem_addr,
    output logic [31:0]       cpu_imem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] LOADED = CHECK;
`else
    localparam logic [2:0] LOADED = RUN;
`endif

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [ADDR_W:0]   len_in;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;
    logic              start;
    logic              hs;
    logic              last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{cpu_imem_addr[31:ADDR_W+2], cpu_imem_addr[1:0]};

    assign len_in = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign start  = load_start &&
                    (state == IDLE || state == RUN || state == ERROR);
    assign hs     = s_valid && s_ready;
    assign last   = (cnt + 1'b1) == len_q;

    // Stream acceptance: words only while a non-empty load or the checksum is pending.
    always_comb begin
        s_ready = 1'b0;
        if (state == LOAD)
            s_ready = (len_q != '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state == CHECK)
            s_ready = 1'b1;
`endif
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    // Wrap-around sum of every word accepted during LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sum <= '0;
        else if (start)
            sum <= '0;
        else if (state == LOAD && hs)
            sum <= sum + s_data;
    end

    assign error = (state == ERROR);
`else
    assign error = 1'b0;
`endif

    // Next-state logic; a restart from RUN/ERROR always passes through LOAD
    // so the CPU sees at least one held cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (load_start)
                    state_nx = (len_in == '0) ? LOADED : LOAD;
            end
            LOAD: begin
                if (len_q == '0 || (hs && last))
                    state_nx = LOADED;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (hs)
                    state_nx = (s_data == sum) ? RUN : ERROR;
            end
`endif
            RUN, ERROR: begin
                if (load_start)
                    state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, length latch, word counter, registered write port and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state_nx == RUN) && (state != RUN);
            wr_en <= 1'b0;
            if (start) begin
                len_q <= len_in;
                cnt   <= '0;
            end else if (state == LOAD && hs) begin
                wr_en   <= 1'b1;
                wr_addr <= cnt[ADDR_W-1:0];
                wr_data <= s_data;
                cnt     <= cnt + 1'b1;
            end
        end
    end

    // The final word's write drains in the first RUN cycle; it owns the
    // address bus for that one cycle, after which the CPU fetch port does.
    assign mem_we        = wr_en;
    assign mem_wdata     = wr_data;
    assign cpu_run       = (state == RUN);
    assign mem_addr      = (cpu_run && !wr_en) ?
                           cpu_imem_addr[ADDR_W+1:2] : wr_addr;
    assign cpu_imem_data = cpu_run ? mem_rdata : 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign busy          = (state == LOAD) || (state == CHECK);
`else
    assign busy          = (state == LOAD);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random program loads checked against a queue/array model
// of the loaded image, the write stream and the status pulses.
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic [31:0]   cpu_imem_addr;
    logic [31:0]   cpu_imem_data;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_len(load_len), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .cpu_imem_addr(cpu_imem_addr),
        .cpu_imem_data(cpu_imem_data), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .busy(busy), .done(done), .error(error)
    );

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_img [DEPTH];
    assign mem_rdata = mem[mem_addr];

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          hs_cyc[$];
    logic [31:0] wq[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          run_rise = -1;
    int          bad_done = 0;
    logic        prev_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and observation of writes / status pulses mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
            mem[mem_addr] <= mem_wdata;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (!cpu_run) bad_done = bad_done + 1;
        end
        if (cpu_run && !prev_run) run_rise = cyc;
        prev_run = cpu_run;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input int len);
        wq.delete();
        for (int i = 0; i < len; i++) wq.push_back($urandom);
    endtask

    task automatic clear_obs();
        wa.delete(); wd.delete(); wc.delete(); hs_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] w, input bit rec);
        int t = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 20) begin tick(); t++; end
        if (!s_ready) check("s_ready_wait", {31'd0, s_ready}, 32'd1);
        if (rec) hs_cyc.push_back(cyc);
        tick();
    endtask

    task automatic do_load(input int len, input int gap, input bit poke,
                           input bit bad, input string tag);
        logic [31:0] sum = 32'd0;
        int d0;
        int t = 0;
        clear_obs();
        d0 = done_cnt;
        load_start = 1'b1;
        load_len   = 9'(len);
        tick();
        load_start = 1'b0;
        load_len   = 9'($urandom);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                int ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (ng) begin
                    s_valid = 1'b0; load_start = poke; load_len = 9'd5;
                    tick();
                end
                load_start = 1'b0;
            end
            send_word(wq[i], 1'b1);
            sum += wq[i];
        end
        s_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(bad ? sum + 32'd1 : sum, 1'b0);
        s_valid = 1'b0;
`endif
        while (!cpu_run && !error && t < 20) begin tick(); t++; end
        check({tag, "_end"}, {30'd0, error, cpu_run}, bad ? 32'd2 : 32'd1);
        check({tag, "_rdy"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        tick(); tick();
        check({tag, "_done"}, 32'(done_cnt - d0), bad ? 32'd0 : 32'd1);
        if (!bad) check({tag, "_donepos"}, 32'(done_cyc), 32'(run_rise));
        check({tag, "_nwr"}, 32'(wa.size()), 32'(len));
        for (int i = 0; i < len && i < wa.size(); i++) begin
            check($sformatf("%s_a%0d", tag, i), 32'(wa[i]), 32'(i));
            check($sformatf("%s_d%0d", tag, i), wd[i], wq[i]);
            if (i < hs_cyc.size())
                check($sformatf("%s_l%0d", tag, i),
                      32'(wc[i] - hs_cyc[i]), 32'd1);
        end
        for (int i = 0; i < len; i++) ref_img[i] = wq[i];
    endtask

    task automatic readback(input int n, input int len, input string tag);
        for (int k = 0; k < n; k++) begin
            int i = $urandom_range(0, len - 1);
            logic [31:0] a = $urandom;
            a[AW+1:2] = i[AW-1:0];
            cpu_imem_addr = a;
            #1;
            check($sformatf("%s_ma%0d", tag, k), 32'(mem_addr), 32'(i));
            check($sformatf("%s_rd%0d", tag, k), cpu_imem_data, ref_img[i]);
            tick();
        end
    endtask

    initial begin
        int d0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'hDEAD_0000 + 32'(i);
            ref_img[i] = 32'hDEAD_0000 + 32'(i);
        end
        reset = 1'b1; load_start = 1'b0; load_len = '0;
        s_valid = 1'b0; s_data = '0; cpu_imem_addr = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_rdy",   {31'd0, s_ready}, 32'd0);
        check("rst_we",    {31'd0, mem_we}, 32'd0);
        check("rst_run",   {31'd0, cpu_run}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, error}, 32'd0);
        check("rst_maddr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_idata", cpu_imem_data, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        wq.delete();
        wq.push_back(32'h11); wq.push_back(32'h22); wq.push_back(32'h33);
        do_load(3, 0, 1'b0, 1'b0, "s1");

        cpu_imem_addr = 32'h8;
        #1;
        check("s3_maddr", 32'(mem_addr), 32'd2);
        check("s3_idata", cpu_imem_data, 32'h33);
        tick();

`ifndef IMEM_LOADER_CHECKSUM_EN
        clear_obs();
        d0 = done_cnt;
        load_start = 1'b1; load_len = '0;
        tick();
        load_start = 1'b0;
        check("s6_hold", {31'd0, cpu_run}, 32'd0);
        tick();
        check("s6_run",  {31'd0, cpu_run}, 32'd1);
        check("s6_done", {31'd0, done}, 32'd1);
        tick(); tick();
        check("s6_ndone", 32'(done_cnt - d0), 32'd1);
        check("s6_nwr", 32'(wa.size()), 32'd0);
`endif

        fill(2);
        do_load(2, 3, 1'b1, 1'b0, "s2");
        readback(2, 2, "s2");

        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(1, 24);
            fill(len);
            do_load(len, -1, r[0], 1'b0, $sformatf("rnd%0d", r));
            readback(4, len, $sformatf("rnd%0d", r));
        end

        fill(DEPTH);
        do_load(DEPTH, 0, 1'b0, 1'b0, "full");
        readback(8, DEPTH, "full");

        clear_obs();
        fill(4);
        d0 = done_cnt;
        load_start = 1'b1; load_len = 9'd4;
        tick();
        load_start = 1'b0;
        send_word(wq[0], 1'b1);
        s_valid = 1'b0;
        tick(); tick();
        s_valid = 1'b1; s_data = wq[1];
        #2 reset = 1'b0;
        #1;
        check("s4_busy", {31'd0, busy}, 32'd0);
        check("s4_run",  {31'd0, cpu_run}, 32'd0);
        check("s4_we",   {31'd0, mem_we}, 32'd0);
        check("s4_rdy",  {31'd0, s_ready}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        repeat (5) tick();
        check("s4_nwr",   32'(wa.size()), 32'd1);
        check("s4_ndone", 32'(done_cnt - d0), 32'd0);
        check("s4_run2",  {31'd0, cpu_run}, 32'd0);
        check("s4_busy2", {31'd0, busy}, 32'd0);
        s_valid = 1'b0;
        ref_img[0] = wq[0];
        cpu_imem_addr = 32'h8;
        #1;
        check("s3_idle_idata", cpu_imem_data, 32'd0);
        tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
        wq.delete();
        wq.push_back(32'hFFFF_FFFF); wq.push_back(32'h2);
        do_load(2, 0, 1'b0, 1'b0, "s5ok");
        do_load(2, 0, 1'b0, 1'b1, "s5bad");
        check("s5_err", {31'd0, error}, 32'd1);
        check("s5_run", {31'd0, cpu_run}, 32'd0);
        load_start = 1'b1; load_len = 9'd1;
        tick();
        load_start = 1'b0;
        check("s5_busy", {31'd0, busy}, 32'd1);
        check("s5_err0", {31'd0, error}, 32'd0);
        fill(1);
        send_word(wq[0], 1'b0);
        send_word(wq[0], 1'b0);
        s_valid = 1'b0;
        begin
            int t = 0;
            while (!cpu_run && t < 20) begin tick(); t++; end
        end
        check("s5_rerun", {31'd0, cpu_run}, 32'd1);
        ref_img[0] = wq[0];
`endif

        check("done_outside_run", 32'(bad_done), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
